xor_initiator: RTL and testbench



---
 rtl/xor_initiator_if.sv | 23 ++
 rtl/xor_initiator.sv | 188 ++++++++++++++++++
 tb/tb_xor_initiator.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_initiator_if.sv
// Operand (A, B) and result (Y) en/rdy channels between the XOR initiator
// (master) and the XOR responder (slave).
interface xor_initiator_if;
    logic a_data;
    logic a_en;
    logic a_rdy;
    logic b_data;
    logic b_en;
    logic b_rdy;
    logic y_data;
    logic y_en;
    logic y_rdy;

    modport master (
        output a_data, a_en, b_data, b_en, y_rdy,
        input  a_rdy, b_rdy, y_data, y_en
    );

    modport slave (
        input  a_data, a_en, b_data, b_en, y_rdy,
        output a_rdy, b_rdy, y_data, y_en
    );
endinterface

// File: rtl/xor_initiator.sv
// Bus-functional XOR initiator: launches operand pairs to the responder,
// scoreboards the expected a^b results and counts pass/fail/unexpected returns.
module xor_initiator #(
    parameter int DEPTH   = 4,
    parameter int CW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     cmd_valid,
    input  logic                     cmd_a,
    input  logic                     cmd_b,
    output logic                     cmd_rdy,
    xor_initiator_if.master          bus,
    input  logic                     y_stall,
    output logic [CW-1:0]            pass_cnt,
    output logic [CW-1:0]            fail_cnt,
    output logic [CW-1:0]            unexp_cnt,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     idle,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] TIMEOUT_V = WW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          a_en_q, a_en_d;
    logic          b_en_q, b_en_d;
    logic          a_data_q, a_data_d;
    logic          b_data_q, b_data_d;
    logic          exp_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] pass_q, pass_d;
    logic [CW-1:0] fail_q, fail_d;
    logic [CW-1:0] unexp_q, unexp_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;

    logic push;
    logic pop;
    logic a_xfer;
    logic b_xfer;
    logic y_xfer;
    logic fifo_empty;
    logic head_match;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign a_xfer     = a_en_q && bus.a_rdy;
    assign b_xfer     = b_en_q && bus.b_rdy;
    // y_rdy never depends on the scoreboard so stray results always drain.
    assign y_xfer     = bus.y_en && !y_stall;
    assign fifo_empty = (cnt_q == '0);
    assign head_match = (bus.y_data == exp_q[rd_ptr_q]);
    assign pop        = y_xfer && !fifo_empty;

    // Operand launch FSM
    always_comb begin
        state_d  = state_q;
        a_en_d   = a_en_q;
        b_en_d   = b_en_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        cmd_rdy  = 1'b0;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_rdy = (cnt_q < DEPTH_V);
                if (cmd_valid && cmd_rdy) begin
                    push     = 1'b1;
                    a_data_d = cmd_a;
                    b_data_d = cmd_b;
                    a_en_d   = 1'b1;
                    b_en_d   = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // a_en/b_en double as the not-done flags of each channel.
                if (a_xfer) a_en_d = 1'b0;
                if (b_xfer) b_en_d = 1'b0;
                if (!a_en_d && !b_en_d) state_d = HOLD;
            end
            HOLD: begin
                // Operand data stays put one more edge for the responder.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                a_en_d  = 1'b0;
                b_en_d  = 1'b0;
            end
        endcase
    end

    // Scoreboard, counters and watchdog
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        unexp_d  = unexp_q;
        wdog_d   = wdog_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (head_match) pass_d = sat_inc(pass_q);
            else            fail_d = sat_inc(fail_q);
        end
        if (y_xfer && fifo_empty) unexp_d = sat_inc(unexp_q);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (y_xfer || fifo_empty)      wdog_d = '0;
        else if (wdog_q != TIMEOUT_V)  wdog_d = wdog_q + 1'b1;
        timeout_d = timeout_q || (wdog_d == TIMEOUT_V);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            a_en_q    <= 1'b0;
            b_en_q    <= 1'b0;
            a_data_q  <= 1'b0;
            b_data_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            unexp_q   <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_en_q    <= a_en_d;
            b_en_q    <= b_en_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            unexp_q   <= unexp_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Expected-result storage; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (push) exp_q[wr_ptr_q] <= cmd_a ^ cmd_b;
    end

    assign bus.a_en   = a_en_q;
    assign bus.b_en   = b_en_q;
    assign bus.a_data = a_data_q;
    assign bus.b_data = b_data_q;
    assign bus.y_rdy  = !y_stall;

    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;
    assign unexp_cnt   = unexp_q;
    assign outstanding = cnt_q;
    assign idle        = (state_q == IDLE) && fifo_empty;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_xor_initiator.sv
// Directed bench for xor_initiator with a small XOR responder model that can
// invert a result, inject an extra result or withhold results.
module tb_xor_initiator;

    localparam int DEPTH   = 4;
    localparam int CW      = 16;
    localparam int TIMEOUT = 40;
    localparam int OW      = $clog2(DEPTH) + 1;

    logic          CLK       = 1'b0;
    logic          RST_N     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_a     = 1'b0;
    logic          cmd_b     = 1'b0;
    logic          cmd_rdy;
    logic          y_stall   = 1'b0;
    logic          a_rdy     = 1'b0;
    logic          b_rdy     = 1'b0;
    logic          hold_y    = 1'b0;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] unexp_cnt;
    logic [OW-1:0] outstanding;
    logic          idle;
    logic          timeout;

    int checks = 0;
    int errors = 0;

    // Responder model state: test side writes *_req, responder writes *_done.
    int   inv_req    = 0;
    int   inv_done   = 0;
    int   extra_req  = 0;
    int   extra_done = 0;
    int   rq_n       = 0;
    logic rq_head    = 1'b0;
    logic rq[$];
    logic ylog[$];
    time  last_acc_t = 0;

    xor_initiator_if bus();

    assign bus.a_rdy  = a_rdy;
    assign bus.b_rdy  = b_rdy;
    assign bus.y_en   = !hold_y && ((rq_n > 0) || (extra_req != extra_done));
    assign bus.y_data = rq_head;

    xor_initiator #(
        .DEPTH   (DEPTH),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .cmd_valid   (cmd_valid),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_rdy     (cmd_rdy),
        .bus         (bus),
        .y_stall     (y_stall),
        .pass_cnt    (pass_cnt),
        .fail_cnt    (fail_cnt),
        .unexp_cnt   (unexp_cnt),
        .outstanding (outstanding),
        .idle        (idle),
        .timeout     (timeout)
    );

    always #5 CLK = ~CLK;

    // Responder: samples transfers at the edge, updates its outputs 1 ns later.
    initial begin : responder
        logic ax, bx, yx, av, bv, yv, rst, got_a, got_b, sa, sb, y;
        got_a = 1'b0;
        got_b = 1'b0;
        sa    = 1'b0;
        sb    = 1'b0;
        forever begin
            @(posedge CLK);
            rst = !RST_N;
            ax  = bus.a_en && bus.a_rdy;
            bx  = bus.b_en && bus.b_rdy;
            yx  = bus.y_en && bus.y_rdy;
            av  = bus.a_data;
            bv  = bus.b_data;
            yv  = bus.y_data;
            #1;
            if (rst) begin
                rq.delete();
                got_a      = 1'b0;
                got_b      = 1'b0;
                inv_done   = inv_req;
                extra_done = extra_req;
            end else begin
                if (yx) begin
                    ylog.push_back(yv);
                    if (rq.size() > 0) y = rq.pop_front();
                    else               extra_done++;
                end
                if (ax) begin got_a = 1'b1; sa = av; end
                if (bx) begin got_b = 1'b1; sb = bv; end
                if (got_a && got_b) begin
                    y = sa ^ sb;
                    if (inv_req != inv_done) begin
                        y = ~y;
                        inv_done++;
                    end
                    rq.push_back(y);
                    got_a = 1'b0;
                    got_b = 1'b0;
                end
            end
            rq_n    = rq.size();
            rq_head = (rq_n > 0) ? rq[0] : 1'b0;
        end
    end

    initial begin : global_guard
        #300000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "global timeout");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic a, input logic b, output bit ok);
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_rdy === 1'b1) begin
                @(posedge CLK);
                last_acc_t = $time;
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        a_rdy = 1'b1;
        b_rdy = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.a_en, bus.b_en, bus.a_data, bus.b_data} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_bus: a_en/b_en/a_data/b_data=%b, required 0000",
                     {bus.a_en, bus.b_en, bus.a_data, bus.b_data});
        end
        checks++;
        if (outstanding !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_occ: outstanding=%0d timeout=%b, required 0 0", outstanding, timeout);
        end
        checks++;
        if (pass_cnt !== '0 || fail_cnt !== '0 || unexp_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counters: pass=%0d fail=%0d unexp=%0d, required 0 0 0",
                     pass_cnt, fail_cnt, unexp_cnt);
        end
        checks++;
        if (idle !== 1'b1 || cmd_rdy !== 1'b1 || bus.y_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: idle=%b cmd_rdy=%b y_rdy=%b, required 1 1 1", idle, cmd_rdy, bus.y_rdy);
        end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        bit ok;
        send_cmd(1'b1, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_accept: accepted=%b, required 1", ok);
        end
        checks++;
        if ({bus.a_en, bus.b_en, bus.a_data, bus.b_data, cmd_rdy} !== 5'b11100) begin
            errors++;
            $display("FAIL single_send: en_a,en_b,a,b,cmd_rdy=%b, required 11100",
                     {bus.a_en, bus.b_en, bus.a_data, bus.b_data, cmd_rdy});
        end
        @(negedge CLK);
        checks++;
        if ({bus.a_en, bus.b_en, bus.a_data, bus.b_data, cmd_rdy} !== 5'b00100) begin
            errors++;
            $display("FAIL single_hold: en_a,en_b,a,b,cmd_rdy=%b, required 00100",
                     {bus.a_en, bus.b_en, bus.a_data, bus.b_data, cmd_rdy});
        end
        @(negedge CLK);
        checks++;
        if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_result: pass=%0d fail=%0d idle=%b, required 1 0 1", pass_cnt, fail_cnt, idle);
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        int         base;
        time        t [4];
        logic [1:0] p;
        logic [3:0] exp_y;
        exp_y = 4'b0110;
        base  = ylog.size();
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            send_cmd(p[1], p[0], ok);
            t[i] = last_acc_t;
            checks++;
            if (!ok || cmd_rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_accept%0d: accepted=%b cmd_rdy_in_send=%b, required 1 0", i, ok, cmd_rdy);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_idle: idle never reached, outstanding=%0d", outstanding);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (t[i] - t[i-1] != 30) begin
                errors++;
                $display("FAIL b2b_spacing%0d: %0t, required 30", i, t[i] - t[i-1]);
            end
        end
        checks++;
        if (ylog.size() != base + 4) begin
            errors++;
            $display("FAIL b2b_ycount: %0d results, required 4", ylog.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ylog[base + i] !== exp_y[i]) begin
                    errors++;
                    $display("FAIL b2b_y%0d: y=%b, required %b", i, ylog[base + i], exp_y[i]);
                end
            end
        end
        checks++;
        if (pass_cnt !== 16'd5 || fail_cnt !== 16'd0) begin
            errors++;
            $display("FAIL b2b_counts: pass=%0d fail=%0d, required 5 0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_skew();
        bit ok;
        int bad;
        a_rdy = 1'b0;
        b_rdy = 1'b1;
        send_cmd(1'b0, 1'b1, ok);
        checks++;
        if (!ok || bus.a_en !== 1'b1 || bus.b_en !== 1'b1) begin
            errors++;
            $display("FAIL skew_start: accepted=%b a_en=%b b_en=%b, required 1 1 1", ok, bus.a_en, bus.b_en);
        end
        @(negedge CLK);
        checks++;
        if (bus.a_en !== 1'b1 || bus.b_en !== 1'b0) begin
            errors++;
            $display("FAIL skew_b_done: a_en=%b b_en=%b, required 1 0", bus.a_en, bus.b_en);
        end
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.a_en !== 1'b1 || bus.b_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL skew_a_wait: %0d cycles with a_en dropped or b_en high, required 0", bad);
        end
        a_rdy = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.a_en !== 1'b0 || bus.b_en !== 1'b0 || cmd_rdy !== 1'b0 || bus.b_data !== 1'b1) begin
            errors++;
            $display("FAIL skew_hold: a_en=%b b_en=%b cmd_rdy=%b b_data=%b, required 0 0 0 1",
                     bus.a_en, bus.b_en, cmd_rdy, bus.b_data);
        end
        @(negedge CLK);
        checks++;
        if (cmd_rdy !== 1'b1 || pass_cnt !== 16'd6 || fail_cnt !== 16'd0) begin
            errors++;
            $display("FAIL skew_after: cmd_rdy=%b pass=%0d fail=%0d, required 1 6 0", cmd_rdy, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_stall();
        bit         ok;
        int         bad;
        logic [4:0] av;
        logic [4:0] bv;
        av = 5'b10101;
        bv = 5'b10011;
        a_rdy   = 1'b1;
        b_rdy   = 1'b1;
        y_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            send_cmd(av[i], bv[i], ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stall_accept%0d: accepted=%b, required 1", i, ok);
            end
        end
        cmd_a     = av[DEPTH];
        cmd_b     = bv[DEPTH];
        cmd_valid = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            if (cmd_rdy !== 1'b0 || bus.y_rdy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || outstanding !== OW'(DEPTH)) begin
            errors++;
            $display("FAIL stall_full: rdy_high_cycles=%0d outstanding=%0d, required 0 %0d", bad, outstanding, DEPTH);
        end
        y_stall = 1'b0;
        send_cmd(av[DEPTH], bv[DEPTH], ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_fifth: accepted=%b, required 1", ok);
        end
        wait_idle(ok);
        checks++;
        if (!ok || pass_cnt !== 16'd11 || fail_cnt !== 16'd0 || outstanding !== '0) begin
            errors++;
            $display("FAIL stall_drain: idle=%b pass=%0d fail=%0d outstanding=%0d, required 1 11 0 0",
                     ok, pass_cnt, fail_cnt, outstanding);
        end
    endtask

    task automatic test_fail_unexp();
        bit ok;
        inv_req++;
        send_cmd(1'b1, 1'b1, ok);
        wait_idle(ok);
        checks++;
        if (!ok || fail_cnt !== 16'd1 || pass_cnt !== 16'd11) begin
            errors++;
            $display("FAIL bad_result: idle=%b fail=%0d pass=%0d, required 1 1 11", ok, fail_cnt, pass_cnt);
        end
        extra_req++;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (extra_done == extra_req) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || unexp_cnt !== 16'd1 || fail_cnt !== 16'd1 || pass_cnt !== 16'd11 || outstanding !== '0) begin
            errors++;
            $display("FAIL unexpected: drained=%b unexp=%0d fail=%0d pass=%0d outstanding=%0d, required 1 1 1 11 0",
                     ok, unexp_cnt, fail_cnt, pass_cnt, outstanding);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        hold_y = 1'b1;
        send_cmd(1'b0, 1'b0, ok);
        repeat (TIMEOUT - 1) @(negedge CLK);
        checks++;
        if (!ok || timeout !== 1'b0 || outstanding !== 3'd1) begin
            errors++;
            $display("FAIL timeout_early: accepted=%b timeout=%b outstanding=%0d, required 1 0 1",
                     ok, timeout, outstanding);
        end
        @(negedge CLK);
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: timeout=%b, required 1", timeout);
        end
        hold_y = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || timeout !== 1'b1 || pass_cnt !== 16'd12) begin
            errors++;
            $display("FAIL timeout_sticky: idle=%b timeout=%b pass=%0d, required 1 1 12", ok, timeout, pass_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        hold_y = 1'b1;
        a_rdy  = 1'b1;
        b_rdy  = 1'b1;
        send_cmd(1'b1, 1'b0, ok);
        repeat (2) @(negedge CLK);
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        send_cmd(1'b0, 1'b1, ok);
        checks++;
        if (!ok || outstanding !== 3'd2 || bus.a_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: accepted=%b outstanding=%0d a_en=%b, required 1 2 1", ok, outstanding, bus.a_en);
        end
        RST_N = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.a_en !== 1'b0 || bus.b_en !== 1'b0 || outstanding !== '0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: a_en=%b b_en=%b outstanding=%0d timeout=%b, required 0 0 0 0",
                     bus.a_en, bus.b_en, outstanding, timeout);
        end
        checks++;
        if (pass_cnt !== '0 || fail_cnt !== '0 || unexp_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset_counters: pass=%0d fail=%0d unexp=%0d, required 0 0 0",
                     pass_cnt, fail_cnt, unexp_cnt);
        end
        RST_N  = 1'b1;
        hold_y = 1'b0;
        a_rdy  = 1'b1;
        b_rdy  = 1'b1;
        @(negedge CLK);
        send_cmd(1'b0, 1'b1, ok);
        wait_idle(ok);
        checks++;
        if (!ok || pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || unexp_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_recover: idle=%b pass=%0d fail=%0d unexp=%0d, required 1 1 0 0",
                     ok, pass_cnt, fail_cnt, unexp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_skew();
        test_stall();
        test_fail_unexp();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
